glitch_filter: RTL and testbench

//  Multi-channel digital deglitcher/hazard monitor for asynchronous inputs.
//  - Synchronises WIDTH inputs; forwards a level change only if it persists MIN_PULSE cycles.
//  - Counts shorter pulses (hazards such as delay-induced gate glitches) per channel.
//  - Sits between unregistered combinational logic / pads and clocked consumers.

---
 rtl/glitch_filter_pkg.sv | 20 ++
 rtl/glitch_filter_chan.sv | 107 ++++++++++
 rtl/glitch_filter.sv | 38 +++
 tb/tb_glitch_filter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_filter_pkg.sv
// Shared types and helpers for the multi-channel glitch filter.
package glitch_filter_pkg;

    // Per-channel qualification state
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_e;

    // Ceiling log2, returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/glitch_filter_chan.sv
// One channel: synchroniser, STABLE/PENDING qualifier, run counter, saturating glitch counter.
module glitch_filter_chan
    import glitch_filter_pkg::*;
#(
    parameter int unsigned MIN_PULSE   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             din,
    output logic             dout,
    output logic             chg,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int unsigned      RUN_W    = clog2(MIN_PULSE) + 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   dout_d, chg_d, glitch;
    logic [CNT_W-1:0]       cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser keeps sampling regardless of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    // State, run counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STABLE;
            run_q      <= '0;
            dout       <= 1'b0;
            chg        <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            dout       <= dout_d;
            chg        <= chg_d;
            glitch_cnt <= cnt_d;
        end
    end

    // Next-state, qualification and counter update
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        dout_d  = dout;
        chg_d   = 1'b0;
        glitch  = 1'b0;
        cnt_d   = glitch_cnt;

        if (!en) begin
            // Frozen: any pending change is dropped without counting
            state_d = STABLE;
            run_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (s != dout) begin
                        if (MIN_PULSE == 1) begin
                            dout_d = s;
                            chg_d  = 1'b1;
                        end else begin
                            state_d = PENDING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                PENDING: begin
                    if (s == dout) begin
                        glitch  = 1'b1;
                        state_d = STABLE;
                        run_d   = '0;
                    end else if (run_q >= RUN_LAST) begin
                        dout_d  = s;
                        chg_d   = 1'b1;
                        state_d = STABLE;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    run_d   = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment
        if (clr_cnt)                          cnt_d = '0;
        else if (glitch && glitch_cnt != CNT_MAX) cnt_d = glitch_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/glitch_filter.sv
// Multi-channel deglitcher: replicates one filter channel per input bit.
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MIN_PULSE   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr_cnt,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       chg,
    output logic [WIDTH*CNT_W-1:0] glitch_cnt
);

    // One independent channel per bit, sharing en and clr_cnt
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        glitch_filter_chan #(
            .MIN_PULSE  (MIN_PULSE),
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .clr_cnt   (clr_cnt),
            .din       (din[i]),
            .dout      (dout[i]),
            .chg       (chg[i]),
            .glitch_cnt(glitch_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_glitch_filter.sv
// Scoreboard bench for glitch_filter (main instance CNT_W=8, second instance CNT_W=2).
module tb_glitch_filter;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        en      = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [3:0]  din     = 4'h0;
    logic [3:0]  dout, chg;
    logic [31:0] glitch_cnt;
    logic [3:0]  dout2, chg2;
    logic [7:0]  glitch_cnt2;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  dout;
        logic [3:0]  chg;
        logic [31:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp2_q[$];

    always #5 clk = ~clk;

    glitch_filter #(.WIDTH(4), .MIN_PULSE(3), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt), .din(din),
        .dout(dout), .chg(chg), .glitch_cnt(glitch_cnt)
    );

    glitch_filter #(.WIDTH(4), .MIN_PULSE(3), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt), .din(din),
        .dout(dout2), .chg(chg2), .glitch_cnt(glitch_cnt2)
    );

    function automatic exp_t mk(input logic [3:0] d, input logic [3:0] c, input logic [31:0] n);
        exp_t e;
        e.dout = d; e.chg = c; e.cnt = n;
        return e;
    endfunction

    // Return to a clean idle state, leaving us just after a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din = 4'h0; en = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        #2 rst_n = 1'b0;
        din = 4'hF;
        repeat (3) @(negedge clk);
        vectors++;
        if ({dout, chg, glitch_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_hold: dout=%h chg=%h cnt=%h, expected all zero", dout, chg, glitch_cnt);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) exp_q.push_back(mk(4'h0, 4'h0, 32'h0));
        exp_q.push_back(mk(4'hF, 4'hF, 32'h0));
        exp_q.push_back(mk(4'hF, 4'h0, 32'h0));
        exp_q.push_back(mk(4'hF, 4'h0, 32'h0));
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if ({dout, chg, glitch_cnt} !== e) begin
                miscompares++;
                $display("FAIL reset_release edge %0d: dout=%h chg=%h cnt=%h, expected dout=%h chg=%h cnt=%h",
                         k, dout, chg, glitch_cnt, e.dout, e.chg, e.cnt);
            end
        end
    endtask

    task automatic test_short_glitch();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 4; k++) exp_q.push_back(mk(4'h0, 4'h0, 32'h0));
        for (int k = 5; k <= 8; k++) exp_q.push_back(mk(4'h0, 4'h0, 32'h0000_0001));
        din[0] = 1'b1;
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            if (k == 2) din[0] = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({dout, chg, glitch_cnt} !== e) begin
                miscompares++;
                $display("FAIL short_glitch edge %0d: dout=%h chg=%h cnt=%h, expected dout=%h chg=%h cnt=%h",
                         k, dout, chg, glitch_cnt, e.dout, e.chg, e.cnt);
            end
        end
    endtask

    task automatic test_min_pulse();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 4; k++) exp_q.push_back(mk(4'h0, 4'h0, 32'h0));
        exp_q.push_back(mk(4'h2, 4'h2, 32'h0));
        exp_q.push_back(mk(4'h2, 4'h0, 32'h0));
        exp_q.push_back(mk(4'h2, 4'h0, 32'h0));
        exp_q.push_back(mk(4'h0, 4'h2, 32'h0));
        exp_q.push_back(mk(4'h0, 4'h0, 32'h0));
        exp_q.push_back(mk(4'h0, 4'h0, 32'h0));
        din[1] = 1'b1;
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            if (k == 3) din[1] = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({dout, chg, glitch_cnt} !== e) begin
                miscompares++;
                $display("FAIL min_pulse edge %0d: dout=%h chg=%h cnt=%h, expected dout=%h chg=%h cnt=%h",
                         k, dout, chg, glitch_cnt, e.dout, e.chg, e.cnt);
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] e2;
        int unsigned prev, cur;
        do_reset();
        prev = 0;
        for (int p = 0; p < 5; p++) begin
            cur = (prev < 3) ? prev + 1 : 3;
            for (int k = 1; k <= 5; k++) exp2_q.push_back(8'(((k >= 4) ? cur : prev) << 4));
            din[2] = 1'b1;
            for (int k = 1; exp2_q.size() > 0; k++) begin
                @(posedge clk); #1;
                if (k == 1) din[2] = 1'b0;
                e2 = exp2_q.pop_front();
                vectors++;
                if (glitch_cnt2 !== e2 || dout2 !== 4'h0) begin
                    miscompares++;
                    $display("FAIL saturate pulse %0d edge %0d: cnt=%h dout=%h, expected cnt=%h dout=0",
                             p, k, glitch_cnt2, dout2, e2);
                end
            end
            prev = cur;
        end
    endtask

    task automatic test_clr_priority();
        exp_t e;
        logic [7:0] prev, cur;
        do_reset();
        prev = 8'd0;
        for (int p = 0; p < 7; p++) begin
            cur = (p < 5) ? 8'(p + 1) : ((p == 5) ? 8'd0 : 8'd1);
            for (int k = 1; k <= 5; k++)
                exp_q.push_back(mk(4'h0, 4'h0, {((k >= 4) ? cur : prev), 24'h0}));
            din[3] = 1'b1;
            for (int k = 1; exp_q.size() > 0; k++) begin
                @(posedge clk); #1;
                if (k == 1) din[3] = 1'b0;
                if (k == 3) clr_cnt = (p == 5);
                if (k == 4) clr_cnt = 1'b0;
                e = exp_q.pop_front();
                vectors++;
                if ({dout, chg, glitch_cnt} !== e) begin
                    miscompares++;
                    $display("FAIL clr_priority pulse %0d edge %0d: cnt=%h, expected cnt=%h (dout=%h chg=%h)",
                             p, k, glitch_cnt, e.cnt, dout, chg);
                end
            end
            prev = cur;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 4; k++) exp_q.push_back(mk(4'h0, 4'h0, 32'h0));
        exp_q.push_back(mk(4'h1, 4'h1, 32'h0001_0000));
        exp_q.push_back(mk(4'h1, 4'h0, 32'h0001_0000));
        din = 4'b0101;
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            if (k == 2) din[2] = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({dout, chg, glitch_cnt} !== e) begin
                miscompares++;
                $display("FAIL back_to_back edge %0d: dout=%h chg=%h cnt=%h, expected dout=%h chg=%h cnt=%h",
                         k, dout, chg, glitch_cnt, e.dout, e.chg, e.cnt);
            end
        end
    endtask

    task automatic test_enable_and_reset();
        exp_t e;
        do_reset();
        // Setup: one glitch on channel 1, then settle dout to 4'h4
        din[1] = 1'b1;
        @(posedge clk); #1; din[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 din = 4'h4;
        repeat (6) @(posedge clk);
        #1;
        // Frozen while toggling
        en = 1'b0;
        din = 4'hA;
        for (int k = 1; k <= 14; k++) exp_q.push_back(mk(4'h4, 4'h0, 32'h0000_0100));
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            if (k < 10)       din = (k % 2 == 1) ? 4'h5 : 4'hA;
            else if (k == 10) din = 4'h6;
            e = exp_q.pop_front();
            vectors++;
            if ({dout, chg, glitch_cnt} !== e) begin
                miscompares++;
                $display("FAIL enable_freeze cycle %0d: dout=%h chg=%h cnt=%h, expected dout=%h chg=%h cnt=%h",
                         k, dout, chg, glitch_cnt, e.dout, e.chg, e.cnt);
            end
        end
        // Re-enable with a held mismatch: fresh MIN_PULSE qualification
        en = 1'b1;
        exp_q.push_back(mk(4'h4, 4'h0, 32'h0000_0100));
        exp_q.push_back(mk(4'h4, 4'h0, 32'h0000_0100));
        exp_q.push_back(mk(4'h6, 4'h2, 32'h0000_0100));
        exp_q.push_back(mk(4'h6, 4'h0, 32'h0000_0100));
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if ({dout, chg, glitch_cnt} !== e) begin
                miscompares++;
                $display("FAIL enable_requalify edge %0d: dout=%h chg=%h cnt=%h, expected dout=%h chg=%h cnt=%h",
                         k, dout, chg, glitch_cnt, e.dout, e.chg, e.cnt);
            end
        end
        // Async reset while channels 0 and 3 are pending
        din = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({dout, chg, glitch_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_pending_async: dout=%h chg=%h cnt=%h, expected all zero", dout, chg, glitch_cnt);
        end
        @(posedge clk); #1;
        vectors++;
        if ({dout, chg, glitch_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_pending_hold: dout=%h chg=%h cnt=%h, expected all zero", dout, chg, glitch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        din = 4'h0;
    endtask

    initial begin
        test_reset();
        test_short_glitch();
        test_min_pulse();
        test_saturate();
        test_clr_priority();
        test_back_to_back();
        test_enable_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
